regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter_if.sv | 24 ++
 rtl/regfile_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_arbiter_if -- one requester port of the register-file arbiter.
//
// Signals:
//   req      requester -> arbiter  access request (level, sampled while idle)
//   op       requester -> arbiter  {write, read2, read1} enables
//   addr     requester -> arbiter  {wr_addr, rd_addr2, rd_addr1}, 5 bits each
//   wr_data  requester -> arbiter  write data
//   gnt      arbiter -> requester  one-cycle pulse: request accepted, operands latched
//   done     arbiter -> requester  one-cycle pulse: access complete, rdata valid
//   rdata    arbiter -> requester  {read2 data, read1 data}, held until next done
// ---------------------------------------------------------------------------
interface regfile_arbiter_if;
  logic        req;
  logic [2:0]  op;
  logic [14:0] addr;
  logic [15:0] wr_data;
  logic        gnt;
  logic        done;
  logic [31:0] rdata;

  modport master (output req, op, addr, wr_data, input gnt, done, rdata);
  modport slave  (input req, op, addr, wr_data, output gnt, done, rdata);
endinterface

// File: rtl/regfile_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_arbiter -- round-robin arbiter sharing one three-phase register
// file between two requesters (a_port, b_port).
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   a_port, b_port             requester ports (regfile_arbiter_if.slave)
//   rf_read_enable1/2          registered register-file read enables
//   rf_write_enable            registered register-file write enable
//   rf_read_address1/2         registered read addresses
//   rf_write_address           registered write address
//   rf_write_in                registered write data
//   rf_read_out1/2             register-file read data
//
// The register file commits an access on the third posedge that sees any
// enable high. A mirror of that phase is kept outside of reset so that an
// access cut short by reset can be walked to completion (FLUSH) before new
// work is accepted.
// ---------------------------------------------------------------------------
module regfile_arbiter (
  input  logic             clk,
  input  logic             reset,
  regfile_arbiter_if.slave a_port,
  regfile_arbiter_if.slave b_port,
  output logic             rf_read_enable1,
  output logic             rf_read_enable2,
  output logic             rf_write_enable,
  output logic [4:0]       rf_read_address1,
  output logic [4:0]       rf_read_address2,
  output logic [4:0]       rf_write_address,
  output logic [15:0]      rf_write_in,
  input  logic [15:0]      rf_read_out1,
  input  logic [15:0]      rf_read_out2
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, FLUSH} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  phase_reg, phase_next;
  logic        owner_reg, owner_next;     // 1: b_port owns the current access
  logic        last_b_reg, last_b_next;   // 1: b_port was granted most recently
  logic [2:0]  op_reg, op_next;
  logic        a_gnt_reg, a_gnt_next, b_gnt_reg, b_gnt_next;
  logic        a_done_reg, a_done_next, b_done_reg, b_done_next;
  logic [31:0] a_rdata_reg, a_rdata_next, b_rdata_reg, b_rdata_next;
  logic        re1_reg, re1_next, re2_reg, re2_next, we_reg, we_next;
  logic [4:0]  ra1_reg, ra1_next, ra2_reg, ra2_next, wa_reg, wa_next;
  logic [15:0] wd_reg, wd_next;

  // Power-on value only: reset must not disturb the register file's view of
  // how many enable edges it has already seen.
  logic [1:0]  mirror_phase_reg = 2'd0;

  logic        win_b;
  logic [2:0]  sel_op;
  logic [14:0] sel_addr;
  logic [15:0] sel_data;

  always_ff @(posedge clk) begin
    if (re1_reg || re2_reg || we_reg) begin
      mirror_phase_reg <= (mirror_phase_reg == 2'd2) ? 2'd0 : mirror_phase_reg + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      phase_reg   <= 2'd0;
      owner_reg   <= 1'b0;
      last_b_reg  <= 1'b1;   // a_port gets first priority
      op_reg      <= 3'd0;
      a_gnt_reg   <= 1'b0;
      b_gnt_reg   <= 1'b0;
      a_done_reg  <= 1'b0;
      b_done_reg  <= 1'b0;
      a_rdata_reg <= 32'd0;
      b_rdata_reg <= 32'd0;
      re1_reg     <= 1'b0;
      re2_reg     <= 1'b0;
      we_reg      <= 1'b0;
      ra1_reg     <= 5'd0;
      ra2_reg     <= 5'd0;
      wa_reg      <= 5'd0;
      wd_reg      <= 16'd0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      owner_reg   <= owner_next;
      last_b_reg  <= last_b_next;
      op_reg      <= op_next;
      a_gnt_reg   <= a_gnt_next;
      b_gnt_reg   <= b_gnt_next;
      a_done_reg  <= a_done_next;
      b_done_reg  <= b_done_next;
      a_rdata_reg <= a_rdata_next;
      b_rdata_reg <= b_rdata_next;
      re1_reg     <= re1_next;
      re2_reg     <= re2_next;
      we_reg      <= we_next;
      ra1_reg     <= ra1_next;
      ra2_reg     <= ra2_next;
      wa_reg      <= wa_next;
      wd_reg      <= wd_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    owner_next   = owner_reg;
    last_b_next  = last_b_reg;
    op_next      = op_reg;
    a_gnt_next   = 1'b0;
    b_gnt_next   = 1'b0;
    a_done_next  = 1'b0;
    b_done_next  = 1'b0;
    a_rdata_next = a_rdata_reg;
    b_rdata_next = b_rdata_reg;
    re1_next     = re1_reg;
    re2_next     = re2_reg;
    we_next      = we_reg;
    ra1_next     = ra1_reg;
    ra2_next     = ra2_reg;
    wa_next      = wa_reg;
    wd_next      = wd_reg;
    // b wins when it is the only requester, or when both ask and a went last
    win_b        = b_port.req && (!a_port.req || !last_b_reg);
    sel_op       = win_b ? b_port.op      : a_port.op;
    sel_addr     = win_b ? b_port.addr    : a_port.addr;
    sel_data     = win_b ? b_port.wr_data : a_port.wr_data;

    case (state_reg)
      IDLE: begin
        if (mirror_phase_reg != 2'd0) begin
          // Register file is mid-access: finish it with a harmless read of r0.
          state_next = FLUSH;
          re1_next   = 1'b1;
          re2_next   = 1'b0;
          we_next    = 1'b0;
          ra1_next   = 5'd0;
          ra2_next   = 5'd0;
          wa_next    = 5'd0;
          wd_next    = 16'd0;
        end else if (a_port.req || b_port.req) begin
          owner_next  = win_b;
          last_b_next = win_b;
          a_gnt_next  = !win_b;
          b_gnt_next  = win_b;
          op_next     = sel_op;
          if (sel_op != 3'd0) begin
            state_next = ACCESS;
            phase_next = 2'd0;
            re1_next   = sel_op[0];
            re2_next   = sel_op[1];
            we_next    = sel_op[2];
            ra1_next   = sel_addr[4:0];
            ra2_next   = sel_addr[9:5];
            wa_next    = sel_addr[14:10];
            wd_next    = sel_data;
          end else begin
            // Empty op: no register-file traffic, complete straight away.
            state_next = CAPTURE;
          end
        end
      end
      ACCESS: begin
        if (phase_reg == 2'd2) begin
          state_next = CAPTURE;
          re1_next   = 1'b0;
          re2_next   = 1'b0;
          we_next    = 1'b0;
          ra1_next   = 5'd0;
          ra2_next   = 5'd0;
          wa_next    = 5'd0;
          wd_next    = 16'd0;
        end else begin
          phase_next = phase_reg + 2'd1;
        end
      end
      CAPTURE: begin
        state_next = IDLE;
        if (owner_reg) begin
          if (op_reg[0]) b_rdata_next[15:0]  = rf_read_out1;
          if (op_reg[1]) b_rdata_next[31:16] = rf_read_out2;
          b_done_next = 1'b1;
        end else begin
          if (op_reg[0]) a_rdata_next[15:0]  = rf_read_out1;
          if (op_reg[1]) a_rdata_next[31:16] = rf_read_out2;
          a_done_next = 1'b1;
        end
      end
      FLUSH: begin
        // The enable is high through this edge, so phase 2 wraps to 0 now.
        if (mirror_phase_reg == 2'd2) begin
          state_next = IDLE;
          re1_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign a_port.gnt       = a_gnt_reg;
  assign b_port.gnt       = b_gnt_reg;
  assign a_port.done      = a_done_reg;
  assign b_port.done      = b_done_reg;
  assign a_port.rdata     = a_rdata_reg;
  assign b_port.rdata     = b_rdata_reg;
  assign rf_read_enable1  = re1_reg;
  assign rf_read_enable2  = re2_reg;
  assign rf_write_enable  = we_reg;
  assign rf_read_address1 = ra1_reg;
  assign rf_read_address2 = ra2_reg;
  assign rf_write_address = wa_reg;
  assign rf_write_in      = wd_reg;

endmodule

// File: tb/tb_regfile_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_arbiter -- self-checking bench for regfile_arbiter.
// A three-phase register-file responder drives rf_read_out*; a transaction
// level model (golden register array, round-robin owner, fixed latencies)
// predicts gnt/done/rdata every cycle. Directed cases first, then random
// traffic, then a reset cut into an access.
// ---------------------------------------------------------------------------
module tb_regfile_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_arbiter_if a_if ();
  regfile_arbiter_if b_if ();

  logic        rf_re1, rf_re2, rf_we;
  logic [4:0]  rf_ra1, rf_ra2, rf_wa;
  logic [15:0] rf_wd;
  logic [15:0] rf_out1 = 16'd0;
  logic [15:0] rf_out2 = 16'd0;

  regfile_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .a_port           (a_if),
    .b_port           (b_if),
    .rf_read_enable1  (rf_re1),
    .rf_read_enable2  (rf_re2),
    .rf_write_enable  (rf_we),
    .rf_read_address1 (rf_ra1),
    .rf_read_address2 (rf_ra2),
    .rf_write_address (rf_wa),
    .rf_write_in      (rf_wd),
    .rf_read_out1     (rf_out1),
    .rf_read_out2     (rf_out2)
  );

  // Register-file responder: commits on the 3rd posedge with any enable high,
  // reads see the contents before the write of the same access.
  logic [15:0] rf_mem [32] = '{default: 16'h0};
  logic [1:0]  rf_phase = 2'd0;
  always @(posedge clk) begin
    if (rf_re1 || rf_re2 || rf_we) begin
      if (rf_phase == 2'd2) begin
        if (rf_re1) rf_out1 <= rf_mem[rf_ra1];
        if (rf_re2) rf_out2 <= rf_mem[rf_ra2];
        if (rf_we)  rf_mem[rf_wa] <= rf_wd;
        rf_phase <= 2'd0;
      end else begin
        rf_phase <= rf_phase + 2'd1;
      end
    end
  end

  // Reference model state
  logic [15:0] gold [32];
  bit          avail, busy, last_b, owner_b, out_a, out_b, rand_en, keep_req;
  int          cnt_down, cyc;
  logic [2:0]  own_op;
  logic [31:0] pend_rdata, exp_rdata_a, exp_rdata_b;
  logic [7:0]  cnt_we, cnt_r1, cnt_r2;
  int          obs_ga, obs_gb, obs_da, obs_db, n_ga;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input bit port_b, input logic [2:0] op,
                         input logic [14:0] addr, input logic [15:0] wd);
    if (port_b) begin
      b_if.op = op; b_if.addr = addr; b_if.wr_data = wd; b_if.req = 1'b1;
    end else begin
      a_if.op = op; a_if.addr = addr; a_if.wr_data = wd; a_if.req = 1'b1;
    end
  endtask

  task automatic model_reset();
    avail = 1; busy = 0; last_b = 1; out_a = 0; out_b = 0;
    exp_rdata_a = 32'd0; exp_rdata_b = 32'd0;
    cyc = 0; obs_ga = -100; obs_gb = -100; obs_da = -100; obs_db = -100;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    check("rst_ctl", {a_if.gnt, b_if.gnt, a_if.done, b_if.done, rf_re1, rf_re2, rf_we}, 32'd0);
    check("rst_bus", {rf_ra1, rf_ra2, rf_wa, rf_wd}, 32'd0);
    check("rst_rdata_a", a_if.rdata, 32'd0);
    check("rst_rdata_b", b_if.rdata, 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  // One clock of model + checks, then drive the next inputs.
  task automatic step();
    logic        exp_ga, exp_gb, exp_da, exp_db, win_b;
    logic [2:0]  op;
    logic [14:0] ad;
    logic [15:0] wd;
    logic [31:0] base;
    @(posedge clk);
    #1;
    cyc++;
    exp_ga = 0; exp_gb = 0; exp_da = 0; exp_db = 0;
    if (avail && (a_if.req || b_if.req)) begin
      win_b   = b_if.req && (!a_if.req || !last_b);
      last_b  = win_b;
      owner_b = win_b;
      op      = win_b ? b_if.op : a_if.op;
      ad      = win_b ? b_if.addr : a_if.addr;
      wd      = win_b ? b_if.wr_data : a_if.wr_data;
      own_op  = op;
      base    = win_b ? exp_rdata_b : exp_rdata_a;
      if (op[0]) base[15:0]  = gold[ad[4:0]];
      if (op[1]) base[31:16] = gold[ad[9:5]];
      if (op[2]) gold[ad[14:10]] = wd;
      pend_rdata = base;
      busy = 1; avail = 0;
      cnt_down = (op == 3'd0) ? 1 : 4;
      cnt_we = 0; cnt_r1 = 0; cnt_r2 = 0;
      if (win_b) begin exp_gb = 1; out_b = 1; end
      else begin exp_ga = 1; out_a = 1; end
    end else if (busy) begin
      cnt_down--;
    end
    if (busy) begin
      cnt_we = cnt_we + {7'd0, rf_we};
      cnt_r1 = cnt_r1 + {7'd0, rf_re1};
      cnt_r2 = cnt_r2 + {7'd0, rf_re2};
    end
    if (busy && cnt_down == 0) begin
      check("en_cycles", {cnt_we, cnt_r2, cnt_r1},
            {own_op[2] ? 8'd3 : 8'd0, own_op[1] ? 8'd3 : 8'd0, own_op[0] ? 8'd3 : 8'd0});
      if (owner_b) begin exp_db = 1; exp_rdata_b = pend_rdata; out_b = 0; end
      else begin exp_da = 1; exp_rdata_a = pend_rdata; out_a = 0; end
      busy = 0; avail = 1;
    end
    check("a_gnt", a_if.gnt, exp_ga);
    check("b_gnt", b_if.gnt, exp_gb);
    check("a_done", a_if.done, exp_da);
    check("b_done", b_if.done, exp_db);
    check("a_rdata", a_if.rdata, exp_rdata_a);
    check("b_rdata", b_if.rdata, exp_rdata_b);
    if (!busy) check("idle_en", {rf_re1, rf_re2, rf_we}, 32'd0);
    if (a_if.gnt) begin obs_ga = cyc; n_ga++; end
    if (b_if.gnt) obs_gb = cyc;
    if (a_if.done) obs_da = cyc;
    if (b_if.done) obs_db = cyc;
    if (exp_ga && !keep_req) a_if.req = 1'b0;
    if (exp_gb && !keep_req) b_if.req = 1'b0;
    if (rand_en && !a_if.req && !out_a && $urandom_range(0, 2) == 0)
      set_req(0, 3'($urandom_range(0, 7)),
              {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
              16'($urandom));
    if (rand_en && !b_if.req && !out_b && $urandom_range(0, 2) == 0)
      set_req(1, 3'($urandom_range(0, 7)),
              {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
              16'($urandom));
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((busy || a_if.req || b_if.req) && n < max);
    check("settle", {busy, a_if.req, b_if.req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] saved;
    int          n0, n, fl;
    for (int i = 0; i < 32; i++) gold[i] = 16'h0;
    a_if.req = 0; a_if.op = 0; a_if.addr = 0; a_if.wr_data = 0;
    b_if.req = 0; b_if.op = 0; b_if.addr = 0; b_if.wr_data = 0;
    rand_en = 0; keep_req = 0; n_ga = 0;
    do_reset(3);

    // Write 0xBEEF to r5, then read it back on read1.
    set_req(0, 3'b100, {5'd5, 5'd0, 5'd0}, 16'hBEEF);
    run_until_idle(20);
    check("w_gnt_cycle", 32'(obs_ga), 32'd1);
    check("w_done_cycle", 32'(obs_da), 32'd5);
    set_req(0, 3'b001, {5'd0, 5'd0, 5'd5}, 16'h0);
    run_until_idle(20);
    check("rd_beef", {16'h0, a_if.rdata[15:0]}, 32'h0000BEEF);

    // Simultaneous requests after reset: a first, b five cycles later.
    do_reset(2);
    set_req(0, 3'b001, {5'd0, 5'd0, 5'd5}, 16'h0);
    set_req(1, 3'b011, {5'd0, 5'd0, 5'd5}, 16'h0);
    run_until_idle(30);
    check("rr_a_first", 32'(obs_ga), 32'd1);
    check("rr_gap", 32'(obs_gb - obs_ga), 32'd5);
    check("b_rd2_rd1", b_if.rdata, 32'h0000BEEF);

    // Empty op: done the cycle after grant, no register-file activity.
    set_req(1, 3'b000, 15'h7FFF, 16'hFFFF);
    run_until_idle(20);
    check("nop_latency", 32'(obs_db - obs_gb), 32'd1);

    // Request held high across done is served again.
    keep_req = 1;
    n0 = n_ga;
    set_req(0, 3'b001, {5'd0, 5'd0, 5'd5}, 16'h0);
    n = 0;
    while (n_ga < n0 + 2 && n < 20) begin step(); n++; end
    a_if.req = 1'b0;
    keep_req = 0;
    check("held_req_regrant", 32'(n_ga - n0), 32'd2);
    run_until_idle(20);

    // Random traffic on both ports.
    rand_en = 1;
    repeat (400) step();
    rand_en = 0;
    run_until_idle(60);

    // Reset after two access cycles of a write to r9: write is dropped,
    // one flush cycle completes the register-file phase.
    saved = gold[9];
    set_req(0, 3'b100, {5'd9, 5'd0, 5'd0}, 16'h1234);
    n = 0;
    do begin step(); n++; end while (!a_if.gnt && n < 10);
    check("fl_gnt", a_if.gnt, 32'd1);
    step();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("fl_rst_ctl", {a_if.gnt, b_if.gnt, a_if.done, b_if.done, rf_re1, rf_re2, rf_we}, 32'd0);
    reset = 1'b0;
    gold[9] = saved;
    model_reset();
    fl = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("fl_no_gnt_done", {a_if.gnt, b_if.gnt, a_if.done, b_if.done}, 32'd0);
      if (rf_re1) begin
        fl++;
        check("fl_bus", {rf_re2, rf_we, rf_ra1}, 32'd0);
      end else if (fl > 0 || i >= 3) begin
        break;
      end
    end
    check("fl_len", 32'(fl), 32'd1);
    check("rf_phase_after_fl", {30'd0, rf_phase}, 32'd0);
    set_req(0, 3'b001, {5'd0, 5'd0, 5'd9}, 16'h0);
    run_until_idle(20);
    check("fl_write_dropped", {16'h0, a_if.rdata[15:0]}, {16'h0, saved});
    set_req(1, 3'b100, {5'd7, 5'd0, 5'd0}, 16'hA5C3);
    run_until_idle(20);
    set_req(1, 3'b011, {5'd0, 5'd9, 5'd7}, 16'h0);
    run_until_idle(20);
    check("post_fl_rd", b_if.rdata, {saved, 16'hA5C3});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
